// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Definitions shared by the UART receiver, transmitter and baud generator:
// default framing constants and the receiver state encoding.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops are
// set to 1 on reset so an idle line never looks like a start edge.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high
//   din    in   asynchronous serial line
//   dout   out  line value synchronized to clk
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
// Recovers 8N1-style frames (start, DATA_BITS LSB first, stop; idle high)
// from an asynchronous serial line, sampling mid-bit on an oversampled tick.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   sample_tick  in   one-clk pulse at OVERSAMPLE x baud
//   uart_rx      in   asynchronous serial line, idle high
//   data         out  last correctly framed byte, held until the next one
//   data_valid   out  one-cycle pulse when data updates
//   frame_error  out  one-cycle pulse when the stop bit is sampled low
//   busy         out  high whenever the FSM is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (uart_rx),
    .dout  (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end

        ST_START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A line that is high again at mid-start was only a glitch.
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Right shift: the first bit received ends up in the LSB.
            shift_d    = DATA_BITS'({rx_s, shift_q} >> 1);
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            // Leaving at the stop midpoint leaves half a bit of slack to
            // catch a start bit that directly follows.
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          // A held-low line must go high before a new start is accepted.
          if (rx_s) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       uart_rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int tick_div = 1;
  int tick_ph  = 0;
  int cyc      = 0;
  int passes   = 0;
  int total    = 0;

  int         dv_count = 0;
  int         fe_count = 0;
  int         dv_long  = 0;
  int         fe_long  = 0;
  int         both_cnt = 0;
  logic [7:0] dv_last  = 8'h00;
  int         dv_cyc   = 0;
  logic       dv_busy  = 1'b0;
  logic       dv_busy_before = 1'b0;
  logic       dv_prev  = 1'b0;
  logic       fe_prev  = 1'b0;
  logic       busy_prev = 1'b0;
  logic [7:0] dv_hist [0:1];

  int start_cyc;
  int dv_ref;

  uart_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .uart_rx     (uart_rx),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tick_div <= 1) begin
      sample_tick = 1'b1;
    end else begin
      sample_tick = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % tick_div;
    end
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_hist[0] = dv_hist[1];
      dv_hist[1] = data;
      dv_count++;
      dv_last = data;
      dv_cyc  = cyc;
      dv_busy = busy;
      dv_busy_before = busy_prev;
      if (dv_prev) dv_long++;
    end
    if (frame_error) begin
      fe_count++;
      if (fe_prev) fe_long++;
    end
    if (data_valid && frame_error) both_cnt++;
    dv_prev   = data_valid;
    fe_prev   = frame_error;
    busy_prev = busy;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (UART_OVERSAMPLE * tick_div) @(negedge clk);
    end
  endtask

  task automatic send_frame_timed(input logic [7:0] b, input realtime bit_ns);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      #(bit_ns);
    end
  endtask

  task automatic wait_dv(input int n, input int budget);
    for (int k = 0; k < budget && dv_count < n; k++) @(negedge clk);
    check("dv_timeout", dv_count >= n, 1);
  endtask

  initial begin
    dv_hist[0] = 8'h00;
    dv_hist[1] = 8'h00;
    reset = 1'b1;
    uart_rx = 1'b1;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_fe", frame_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);

    // reset in the middle of a frame
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", busy, 1);
    uart_rx = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    repeat (200) @(negedge clk);
    check("post_rst_dv", dv_count, 0);
    check("post_rst_fe", fe_count, 0);
    check("post_rst_busy2", busy, 0);

    // single frame with latency check
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    check("a5_count", dv_count, 1);
    check("a5_data", data, 8'hA5);
    check("a5_dv_data", dv_last, 8'hA5);
    check("a5_latency", dv_cyc - start_cyc, 155);
    check("a5_busy_at_dv", dv_busy, 0);
    check("a5_busy_before", dv_busy_before, 1);

    // back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", dv_count, 3);
    check("b2b_first", dv_hist[0], 8'h00);
    check("b2b_second", dv_hist[1], 8'hFF);
    check("b2b_fe", fe_count, 0);

    // bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("fe_count", fe_count, 1);
    check("fe_dv_count", dv_count, 3);
    check("fe_data_kept", data, 8'hFF);
    check("fe_break_busy", busy, 1);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("fe_recover_busy", busy, 0);
    check("fe_no_more", fe_count, 1);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check("f81_count", dv_count, 4);
    check("f81_data", data, 8'h81);

    // 4-tick glitch is a false start
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    check("gl_busy_start", busy, 1);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    check("gl_busy_last", busy, 1);
    @(negedge clk);
    check("gl_busy_end", busy, 0);
    repeat (20) @(negedge clk);
    check("gl_dv", dv_count, 4);
    check("gl_fe", fe_count, 1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("f3c_count", dv_count, 5);
    check("f3c_data", data, 8'h3C);

    // tick every 4th cycle, line driven off the clock grid
    tick_div = 4;
    repeat (100) @(negedge clk);
    #13;
    send_frame_timed(8'h5A, 640.0);
    @(negedge clk);
    wait_dv(6, 400);
    check("async_data", data, 8'h5A);
    repeat (100) @(negedge clk);
    #27;
    send_frame_timed(8'h96, 665.6);
    @(negedge clk);
    wait_dv(7, 400);
    check("slow_data", data, 8'h96);
    repeat (100) @(negedge clk);
    check("final_dv_count", dv_count, 7);
    check("final_fe_count", fe_count, 1);
    check("dv_width", dv_long, 0);
    check("fe_width", fe_long, 0);
    check("dv_fe_overlap", both_cnt, 0);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
